mmio_arbiter: RTL

MMIO_ARBITER -- requirements
Module: mmio_arbiter

---
 rtl/mmio_arbiter_pkg.sv | 22 ++
 rtl/mmio_arbiter_rr_arb2.sv | 38 +++
 rtl/mmio_arbiter.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mmio_arbiter_pkg.sv
// Shared definitions for the two-requester MMIO arbiter: state encoding,
// bus widths and requester ids.
package mmio_arbiter_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;

    localparam logic M0_ID = 1'b0;
    localparam logic M1_ID = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    // Grant vectors are one-hot, so the id is simply the m1 bit.
    function automatic logic gnt_to_id(input logic [1:0] gnt);
        return gnt[1];
    endfunction

endpackage

// File: rtl/mmio_arbiter_rr_arb2.sv
// Two-way tie-break: round-robin on the last granted id when MMIO_ARB_RR_EN
// is defined, otherwise fixed priority with m0 over m1.
module rr_arb2
    import mmio_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

`ifdef MMIO_ARB_RR_EN
    // On a tie the requester that was not served last wins.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (last == M0_ID) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end
`else
    logic unused_last_s;
    assign unused_last_s = last;

    // Fixed priority: m0 always wins a tie.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = 2'b01;
            default: gnt = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/mmio_arbiter.sv
// Two-requester MMIO arbiter with a one-cycle issue stage and registered
// read return. Define MMIO_ARB_RR_EN for round-robin instead of fixed priority.
module mmio_arbiter
    import mmio_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,

    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_data,
    input  logic [MASK_W-1:0] i_m0_mask,
    input  logic              i_m0_wren,
    output logic              o_m0_gnt,
    output logic              o_m0_rvalid,
    output logic [DATA_W-1:0] o_m0_rdata,

    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_data,
    input  logic [MASK_W-1:0] i_m1_mask,
    input  logic              i_m1_wren,
    output logic              o_m1_gnt,
    output logic              o_m1_rvalid,
    output logic [DATA_W-1:0] o_m1_rdata,

    output logic [ADDR_W-1:0] o_mmio_addr,
    output logic [DATA_W-1:0] o_mmio_data,
    output logic [MASK_W-1:0] o_mmio_mask,
    output logic              o_mmio_wren,
    input  logic [DATA_W-1:0] i_mmio_data
);

    state_e            state_r;
    logic              id_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] data_r;
    logic [MASK_W-1:0] mask_r;
    logic              wren_r;
    logic              rvalid0_r;
    logic              rvalid1_r;
    logic [DATA_W-1:0] rdata0_r;
    logic [DATA_W-1:0] rdata1_r;

    logic [1:0]        req_s;
    logic [1:0]        arb_gnt_s;
    logic [1:0]        gnt_s;
    logic              transfer_s;
    logic              sel_id_s;
    logic              last_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_data_s;
    logic [MASK_W-1:0] sel_mask_s;
    logic              sel_wren_s;

    assign req_s = {i_m1_req, i_m0_req};

    rr_arb2 u_rr_arb2 (
        .req  (req_s),
        .last (last_s),
        .gnt  (arb_gnt_s)
    );

`ifdef MMIO_ARB_RR_EN
    logic last_r;

    // Remember the last granted requester; reset favours m0 on the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_r <= M1_ID;
        end else if (transfer_s) begin
            last_r <= sel_id_s;
        end else begin
            last_r <= last_r;
        end
    end

    assign last_s = last_r;
`else
    assign last_s = M1_ID;
`endif

    // Grants are only offered from IDLE and never while reset is asserted.
    always_comb begin
        if (rst_n && (state_r == IDLE)) begin
            gnt_s = arb_gnt_s & req_s;
        end else begin
            gnt_s = 2'b00;
        end
    end

    assign transfer_s = |gnt_s;
    assign sel_id_s   = gnt_to_id(gnt_s);

    // Select the winning requester's payload for latching.
    always_comb begin
        if (sel_id_s == M1_ID) begin
            sel_addr_s = i_m1_addr;
            sel_data_s = i_m1_data;
            sel_mask_s = i_m1_mask;
            sel_wren_s = i_m1_wren;
        end else begin
            sel_addr_s = i_m0_addr;
            sel_data_s = i_m0_data;
            sel_mask_s = i_m0_mask;
            sel_wren_s = i_m0_wren;
        end
    end

    // Main FSM: accept in IDLE, drive downstream in ISSUE, return read data after.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            id_r      <= M0_ID;
            addr_r    <= {ADDR_W{1'b0}};
            data_r    <= {DATA_W{1'b0}};
            mask_r    <= {MASK_W{1'b0}};
            wren_r    <= 1'b0;
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            rdata0_r  <= {DATA_W{1'b0}};
            rdata1_r  <= {DATA_W{1'b0}};
        end else begin
            rvalid0_r <= 1'b0;
            rvalid1_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (transfer_s) begin
                        state_r <= ISSUE;
                        id_r    <= sel_id_s;
                        addr_r  <= sel_addr_s;
                        data_r  <= sel_data_s;
                        mask_r  <= sel_mask_s;
                        wren_r  <= sel_wren_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    state_r <= IDLE;
                    if (!wren_r && (id_r == M1_ID)) begin
                        rvalid1_r <= 1'b1;
                        rdata1_r  <= i_mmio_data;
                    end else if (!wren_r) begin
                        rvalid0_r <= 1'b1;
                        rdata0_r  <= i_mmio_data;
                    end else begin
                        rvalid0_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Downstream bus is quiet in IDLE; a reset landing on ISSUE kills the write strobe.
    always_comb begin
        if (state_r == ISSUE) begin
            o_mmio_addr = addr_r;
            o_mmio_data = data_r;
            o_mmio_mask = mask_r;
            o_mmio_wren = wren_r & rst_n;
        end else begin
            o_mmio_addr = {ADDR_W{1'b0}};
            o_mmio_data = {DATA_W{1'b0}};
            o_mmio_mask = {MASK_W{1'b0}};
            o_mmio_wren = 1'b0;
        end
    end

    assign o_m0_gnt    = gnt_s[0];
    assign o_m1_gnt    = gnt_s[1];
    assign o_m0_rvalid = rvalid0_r;
    assign o_m1_rvalid = rvalid1_r;
    assign o_m0_rdata  = rdata0_r;
    assign o_m1_rdata  = rdata1_r;

endmodule
